// File: rtl/spi_controller.sv
// SPI mode-0 register-access master: one command in, one cmd/addr/data frame out, one response pulse back.
// Commands are accepted only in IDLE; cmd_valid is ignored mid-frame, so a held request waits out the inter-frame gap.
module spi_controller #(
    parameter int unsigned HALF_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        CS_N,
    output logic        SCK,
    output logic        COPI,
    input  logic        CIPO
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] H_LAST = 8'(HALF_DIV - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [5:0]  bit_q;
    logic [5:0]  last_bit_q;
    logic [47:0] tx_q;
    logic [31:0] rx_q;
    logic        is_rd_q;
    logic        cs_n_q;
    logic        sck_q;
    logic        copi_q;
    logic        ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;

    logic [31:0] data_d;
    logic [47:0] frame_d;
    logic [5:0]  last_bit_d;
    logic [5:0]  bit_nxt_d;
    logic        half_done_d;
    logic        accept_d;

    // Data is left-aligned in the frame so the shifter always drains from bit 47.
    always_comb begin
        data_d     = cmd_wdata;
        last_bit_d = 6'd47;
        case (cmd_op[1:0])
            2'b00: begin
                data_d     = {cmd_wdata[7:0], 24'h0};
                last_bit_d = 6'd23;
            end
            2'b01: begin
                data_d     = {cmd_wdata[15:0], 16'h0};
                last_bit_d = 6'd31;
            end
            default: begin
                data_d     = cmd_wdata;
                last_bit_d = 6'd47;
            end
        endcase
        if (cmd_op[2]) begin
            data_d = '0;
        end
        frame_d = {5'b0, cmd_op, cmd_addr, data_d};
    end

    assign half_done_d = (div_q == H_LAST);
    assign bit_nxt_d   = bit_q + 6'd1;
    assign accept_d    = cmd_valid && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            last_bit_q  <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            is_rd_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            copi_q      <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept_d) begin
                        state_q    <= SETUP;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        cs_n_q     <= 1'b0;
                        sck_q      <= 1'b0;
                        div_q      <= '0;
                        bit_q      <= '0;
                        last_bit_q <= last_bit_d;
                        tx_q       <= frame_d;
                        copi_q     <= frame_d[47];
                        rx_q       <= '0;
                        is_rd_q    <= cmd_op[2];
                    end
                end
                SETUP: begin
                    if (half_done_d) begin
                        div_q   <= '0;
                        sck_q   <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (half_done_d) begin
                        div_q <= '0;
                        if (sck_q) begin
                            // The last bit's low phase is spent in HOLD.
                            sck_q <= 1'b0;
                            if (bit_q == last_bit_q) begin
                                state_q <= HOLD;
                            end else begin
                                tx_q   <= {tx_q[46:0], 1'b0};
                                copi_q <= tx_q[46];
                            end
                        end else begin
                            sck_q <= 1'b1;
                            bit_q <= bit_nxt_d;
                            if (is_rd_q && (bit_nxt_d >= 6'd16)) begin
                                rx_q <= {rx_q[30:0], CIPO};
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (half_done_d) begin
                        div_q       <= '0;
                        state_q     <= GAP;
                        cs_n_q      <= 1'b1;
                        copi_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= is_rd_q ? rx_q : 32'h0;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                GAP: begin
                    if (half_done_d) begin
                        div_q   <= '0;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign CS_N      = cs_n_q;
    assign SCK       = sck_q;
    assign COPI      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: HALF_DIV=2 instance for most scenarios, HALF_DIV=1 instance for the fast-clock case.
module tb_spi_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cipo;
    logic        sel;

    logic        a_valid, a_ready, a_rsp_valid, a_busy, a_cs_n, a_sck, a_copi;
    logic [31:0] a_rdata;
    logic        b_valid, b_ready, b_rsp_valid, b_busy, b_cs_n, b_sck, b_copi;
    logic [31:0] b_rdata;

    logic        o_ready, o_rsp_valid, o_busy, o_cs_n, o_sck, o_copi;
    logic [31:0] o_rdata;

    int checks = 0;
    int errors = 0;

    logic [47:0] obs_copi;
    int          obs_cs_low, obs_rises, obs_pulses, obs_copi_bad, obs_sck_bad, obs_busy_bad;
    int          obs_per_min, obs_per_max;
    logic [31:0] obs_rdata;
    logic        obs_edge_ok, obs_timeout;

    always #5 clk = ~clk;

    assign a_valid = cmd_valid & ~sel;
    assign b_valid = cmd_valid & sel;

    spi_controller #(.HALF_DIV(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .busy(a_busy),
        .CS_N(a_cs_n), .SCK(a_sck), .COPI(a_copi), .CIPO(cipo)
    );

    spi_controller #(.HALF_DIV(1)) u_dut_h1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy),
        .CS_N(b_cs_n), .SCK(b_sck), .COPI(b_copi), .CIPO(cipo)
    );

    assign o_ready     = sel ? b_ready     : a_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_rdata     = sel ? b_rdata     : a_rdata;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_cs_n      = sel ? b_cs_n      : a_cs_n;
    assign o_sck       = sel ? b_sck       : a_sck;
    assign o_copi      = sel ? b_copi      : a_copi;

    // Issues one command and watches the bus until the controller is idle again; acts as the CIPO device.
    task automatic do_frame(input logic [2:0] op, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int dbits);
        int cyc, last_rise, k;
        logic prev_sck, prev_cs;
        logic [4:0] bi;
        obs_copi = '0; obs_cs_low = 0; obs_rises = 0; obs_pulses = 0; obs_rdata = '0;
        obs_copi_bad = 0; obs_sck_bad = 0; obs_busy_bad = 0; obs_edge_ok = 1'b0;
        obs_per_min = 1000; obs_per_max = 0; obs_timeout = 1'b0;
        cyc = 0;
        while (!o_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!o_ready) begin
            obs_timeout = 1'b1;
        end else begin
            cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            prev_sck = 1'b0; prev_cs = 1'b1; last_rise = 0; cyc = 0;
            while (!o_ready && cyc < 600) begin
                if (o_sck && !prev_sck) begin
                    if (obs_rises > 0) begin
                        if (cyc - last_rise < obs_per_min) obs_per_min = cyc - last_rise;
                        if (cyc - last_rise > obs_per_max) obs_per_max = cyc - last_rise;
                    end
                    last_rise = cyc;
                    obs_rises++;
                    obs_copi = {obs_copi[46:0], o_copi};
                end
                if (!o_sck) begin
                    k = obs_rises - 16;
                    if (k >= 0 && k < dbits) begin
                        bi   = 5'(dbits - 1 - k);
                        cipo = rd[bi];
                    end else begin
                        cipo = 1'b0;
                    end
                end
                if (!o_cs_n) obs_cs_low++;
                if (o_cs_n && o_copi) obs_copi_bad++;
                if (o_cs_n && o_sck) obs_sck_bad++;
                if (!o_busy) obs_busy_bad++;
                if (o_rsp_valid) begin
                    obs_pulses++;
                    obs_rdata   = o_rdata;
                    obs_edge_ok = o_cs_n && !prev_cs;
                end
                prev_sck = o_sck;
                prev_cs  = o_cs_n;
                @(negedge clk);
                cyc++;
            end
            if (!o_ready) obs_timeout = 1'b1;
            cipo = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (o_cs_n !== 1'b1) begin errors++; $display("FAIL reset cs_n: got %b expected 1", o_cs_n); end
        checks++; if (o_sck !== 1'b0) begin errors++; $display("FAIL reset sck: got %b expected 0", o_sck); end
        checks++; if (o_copi !== 1'b0) begin errors++; $display("FAIL reset copi: got %b expected 0", o_copi); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset cmd_ready: got %b expected 0", o_ready); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", o_busy); end
        checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b expected 0", o_rsp_valid); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL reset rsp_rdata: got %h expected 0", o_rdata); end
        rst_n = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset ready_before_edge: got %b expected 0", o_ready); end
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset ready_after_edge: got %b expected 1", o_ready); end
    endtask

    task automatic test_byte_write();
        do_frame(3'b000, 8'h03, 32'h0000_0055, 32'h0, 8);
        checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL byte_wr timeout: got %b expected 0", obs_timeout); end
        checks++; if (obs_copi !== 48'h000355) begin errors++; $display("FAIL byte_wr copi: got %h expected 000355", obs_copi); end
        checks++; if (obs_cs_low !== 98) begin errors++; $display("FAIL byte_wr cs_low: got %0d expected 98", obs_cs_low); end
        checks++; if (obs_rises !== 24) begin errors++; $display("FAIL byte_wr rises: got %0d expected 24", obs_rises); end
        checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL byte_wr pulses: got %0d expected 1", obs_pulses); end
        checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL byte_wr rdata: got %h expected 0", obs_rdata); end
        checks++; if (obs_edge_ok !== 1'b1) begin errors++; $display("FAIL byte_wr pulse_at_cs_rise: got %b expected 1", obs_edge_ok); end
        checks++; if (obs_per_min !== 4 || obs_per_max !== 4) begin errors++; $display("FAIL byte_wr sck_period: got %0d..%0d expected 4", obs_per_min, obs_per_max); end
        checks++; if (obs_copi_bad !== 0 || obs_sck_bad !== 0) begin errors++; $display("FAIL byte_wr idle_bus: got copi %0d sck %0d expected 0", obs_copi_bad, obs_sck_bad); end
        checks++; if (obs_busy_bad !== 0) begin errors++; $display("FAIL byte_wr busy: got %0d low cycles expected 0", obs_busy_bad); end
    endtask

    task automatic test_halfword_write();
        do_frame(3'b001, 8'h06, 32'h1234_AABB, 32'h0, 16);
        checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL hw_wr timeout: got %b expected 0", obs_timeout); end
        checks++; if (obs_copi !== 48'h0106AABB) begin errors++; $display("FAIL hw_wr copi: got %h expected 0106aabb", obs_copi); end
        checks++; if (obs_rises !== 32) begin errors++; $display("FAIL hw_wr rises: got %0d expected 32", obs_rises); end
        checks++; if (obs_cs_low !== 130) begin errors++; $display("FAIL hw_wr cs_low: got %0d expected 130", obs_cs_low); end
    endtask

    task automatic test_word_read();
        do_frame(3'b110, 8'h08, 32'hFFFF_FFFF, 32'hCCCC_DDDD, 32);
        checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL word_rd timeout: got %b expected 0", obs_timeout); end
        checks++; if (obs_copi !== 48'h0608_0000_0000) begin errors++; $display("FAIL word_rd copi: got %h expected 060800000000", obs_copi); end
        checks++; if (obs_rdata !== 32'hCCCC_DDDD) begin errors++; $display("FAIL word_rd rdata: got %h expected ccccdddd", obs_rdata); end
        checks++; if (obs_cs_low !== 194) begin errors++; $display("FAIL word_rd cs_low: got %0d expected 194", obs_cs_low); end
        checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL word_rd pulses: got %0d expected 1", obs_pulses); end
        repeat (3) @(negedge clk);
        checks++; if (o_rdata !== 32'hCCCC_DDDD) begin errors++; $display("FAIL word_rd rdata_held: got %h expected ccccdddd", o_rdata); end
    endtask

    task automatic test_byte_read();
        do_frame(3'b100, 8'h10, 32'hFFFF_FFFF, 32'h0000_0055, 8);
        checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL byte_rd timeout: got %b expected 0", obs_timeout); end
        checks++; if (obs_copi !== 48'h041000) begin errors++; $display("FAIL byte_rd copi: got %h expected 041000", obs_copi); end
        checks++; if (obs_rdata !== 32'h0000_0055) begin errors++; $display("FAIL byte_rd rdata: got %h expected 00000055", obs_rdata); end
    endtask

    task automatic test_reset_mid_frame();
        int cyc, rises, rsp_seen;
        logic prev;
        cyc = 0;
        while (!o_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        cmd_op = 3'b010; cmd_addr = 8'h7F; cmd_wdata = 32'h1234_5678; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        prev = o_sck; rises = 0; cyc = 0; rsp_seen = 0;
        while (rises < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_sck && !prev) rises++;
            prev = o_sck;
        end
        checks++; if (o_cs_n !== 1'b0 || o_sck !== 1'b1 || o_copi !== 1'b1) begin errors++; $display("FAIL rst_mid pre_state: got cs %b sck %b copi %b expected 0 1 1", o_cs_n, o_sck, o_copi); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_cs_n !== 1'b1 || o_sck !== 1'b0 || o_copi !== 1'b0) begin errors++; $display("FAIL rst_mid bus: got cs %b sck %b copi %b expected 1 0 0", o_cs_n, o_sck, o_copi); end
        checks++; if (o_busy !== 1'b0 || o_ready !== 1'b0) begin errors++; $display("FAIL rst_mid status: got busy %b ready %b expected 0 0", o_busy, o_ready); end
        checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid rdata: got %h expected 0", o_rdata); end
        repeat (3) begin
            @(negedge clk);
            if (o_rsp_valid) rsp_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (o_rsp_valid) rsp_seen++;
        end
        checks++; if (rsp_seen !== 0) begin errors++; $display("FAIL rst_mid rsp_pulses: got %0d expected 0", rsp_seen); end
        do_frame(3'b010, 8'h21, 32'hDEAD_BEEF, 32'h0, 32);
        checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL rst_mid next_timeout: got %b expected 0", obs_timeout); end
        checks++; if (obs_copi !== 48'h0221_DEAD_BEEF) begin errors++; $display("FAIL rst_mid next_copi: got %h expected 0221deadbeef", obs_copi); end
        checks++; if (obs_cs_low !== 194 || obs_pulses !== 1) begin errors++; $display("FAIL rst_mid next_frame: got cs_low %0d pulses %0d expected 194 1", obs_cs_low, obs_pulses); end
    endtask

    task automatic test_back_to_back();
        int cyc, accepts, pulses, run, gaps, min_gap, pulses_at_acc2;
        logic seen_low, pend;
        cyc = 0;
        while (!o_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        cmd_op = 3'b000; cmd_addr = 8'h11; cmd_wdata = 32'h0000_005A; cmd_valid = 1'b1;
        accepts = 0; pulses = 0; run = 0; gaps = 0; min_gap = 1000; pulses_at_acc2 = -1;
        seen_low = 1'b0; pend = 1'b0; cyc = 0;
        while (!(accepts == 2 && pulses == 2 && o_ready && !cmd_valid) && cyc < 800) begin
            if (pend) begin
                if (accepts == 1) begin
                    cmd_op = 3'b001; cmd_addr = 8'h22; cmd_wdata = 32'h0000_1234;
                end else begin
                    cmd_valid = 1'b0;
                end
                pend = 1'b0;
            end
            if (cmd_valid && o_ready) begin
                accepts++;
                pend = 1'b1;
                if (accepts == 2) pulses_at_acc2 = pulses;
            end
            if (o_rsp_valid) pulses++;
            if (o_cs_n) begin
                run++;
            end else begin
                if (seen_low && run > 0) begin
                    gaps++;
                    if (run < min_gap) min_gap = run;
                end
                run = 0;
                seen_low = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        checks++; if (cyc >= 800) begin errors++; $display("FAIL b2b timeout: got %0d cycles expected < 800", cyc); end
        checks++; if (accepts !== 2) begin errors++; $display("FAIL b2b accepts: got %0d expected 2", accepts); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b pulses: got %0d expected 2", pulses); end
        checks++; if (pulses_at_acc2 !== 1) begin errors++; $display("FAIL b2b second_accept_after_first_rsp: got %0d expected 1", pulses_at_acc2); end
        checks++; if (gaps !== 1 || min_gap < 2) begin errors++; $display("FAIL b2b cs_gap: got gaps %0d min %0d expected 1 gap >= 2", gaps, min_gap); end
    endtask

    task automatic test_half_div_one();
        sel = 1'b1;
        do_frame(3'b000, 8'h3C, 32'h0000_00A5, 32'h0, 8);
        checks++; if (obs_timeout !== 1'b0) begin errors++; $display("FAIL h1 timeout: got %b expected 0", obs_timeout); end
        checks++; if (obs_copi !== 48'h003CA5) begin errors++; $display("FAIL h1 copi: got %h expected 003ca5", obs_copi); end
        checks++; if (obs_cs_low !== 49) begin errors++; $display("FAIL h1 cs_low: got %0d expected 49", obs_cs_low); end
        checks++; if (obs_per_min !== 2 || obs_per_max !== 2) begin errors++; $display("FAIL h1 sck_period: got %0d..%0d expected 2", obs_per_min, obs_per_max); end
        checks++; if (obs_pulses !== 1 || obs_edge_ok !== 1'b1) begin errors++; $display("FAIL h1 rsp: got pulses %0d edge %b expected 1 1", obs_pulses, obs_edge_ok); end
        sel = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        cipo = 1'b0; sel = 1'b0;
        test_reset();
        test_byte_write();
        test_halfword_write();
        test_word_read();
        test_byte_read();
        test_reset_mid_frame();
        test_back_to_back();
        test_half_div_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_DIV, default 2, meaning the SCK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  controller idle and able to accept a command.
REQ-006 SHALL have port cmd_op  input  3  operation: bit2 = read (1) or write (0); bits1:0 = size (00 byte, 01 halfword, 10 word, 11 treated as word).
REQ-007 SHALL have port cmd_addr  input  8  register address.
REQ-008 SHALL have port cmd_wdata  input  32  write data, right-aligned.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata  output  32  read data, right-aligned and zero-extended; 0 for writes.
REQ-011 SHALL have port busy  output  1  high from command accept until return to IDLE.
REQ-012 SHALL have ports CS_N  output  1, SCK  output  1, COPI  output  1 and CIPO  input  1, forming the SPI bus (mode 0, MSB first).

Function
REQ-013 SHALL accept a command on the clk edge where cmd_valid and cmd_ready are both high, and SHALL capture op, addr and wdata on that edge.
REQ-014 SHALL use FSM states IDLE, SETUP, SHIFT, HOLD and GAP: IDLE->SETUP on accept; SETUP->SHIFT after H cycles; SHIFT->HOLD after the last bit's high phase; HOLD->GAP after H cycles; GAP->IDLE after H cycles (H = HALF_DIV).
REQ-015 SHALL assert cmd_ready only in IDLE; cmd_valid in any other state SHALL be ignored and SHALL NOT be queued.
REQ-016 SHALL send a frame of the command byte {5'b0, op}, then the address byte, then D data bits, where D = 8, 16 or 32 according to size; total frame length N = 16 + D bits.
REQ-017 SHALL drive CS_N low from the cycle after accept through the end of HOLD, i.e. exactly H + 2*N*H cycles.
REQ-018 SHALL hold SCK low in SETUP, and in SHIFT each bit SHALL be SCK high for H cycles followed by SCK low for H cycles; SCK SHALL be low in HOLD, GAP and IDLE.
REQ-019 SHALL present the first COPI bit when CS_N falls, and SHALL update COPI on each SCK falling edge; COPI SHALL be 0 outside CS_N low and during read data bits.
REQ-020 For write data, SHALL transmit cmd_wdata[D-1:0] MSB first.
REQ-021 For reads, SHALL sample CIPO on the clk edge where SCK rises, for data bits only, and shift it in MSB first.
REQ-022 SHALL pulse rsp_valid for exactly one cycle, the cycle in which CS_N returns high (HOLD->GAP), with rsp_rdata valid in that cycle and held until the next pulse.
REQ-023 SHALL use a 6-bit bit counter and an SCK half-period counter sized for 255; neither counter SHALL wrap within a frame.
REQ-024 SHALL guarantee CS_N is high for at least H cycles between frames, including when back-to-back commands are issued.

Reset
REQ-025 While rst_n is low (asynchronous), SHALL force: state IDLE, CS_N=1, SCK=0, COPI=0, cmd_ready=0, busy=0, rsp_valid=0, rsp_rdata=0.
REQ-026 SHALL assert cmd_ready on the first clk edge after rst_n deasserts.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with no rsp_valid pulse, and the next command SHALL start a complete new frame.

Verification
REQ-028 Byte write, H=2, op=000, addr=0x03, wdata=0x55 -> COPI bytes 0x00,0x03,0x55; CS_N low for 98 cycles; one rsp_valid pulse with rsp_rdata=0.
REQ-029 Halfword write, op=001, addr=0x06, wdata=0xAABB -> COPI bytes 0x01,0x06,0xAA,0xBB; 32 SCK rising edges.
REQ-030 Word read, op=110, addr=0x08, CIPO model returns 0xCCCCDDDD -> rsp_rdata=0xCCCCDDDD; COPI=0 during data bits. Byte read returning 0x55 -> rsp_rdata=0x00000055.
REQ-031 cmd_valid held high across two commands -> second command accepted only after GAP; CS_N high for at least H cycles between frames; exactly two rsp_valid pulses.
REQ-032 rst_n pulsed low after 10 SCK edges of a word write -> CS_N=1 and SCK=0 immediately; no rsp_valid; the following command completes correctly.
REQ-033 HALF_DIV=1 byte write -> SCK period of 2 clk cycles; CS_N low for 49 cycles; data correct.
